barrett_mu_precompute: RTL and testbench

Iterative precompute unit sitting directly upstream of `barrett_pipelined`. It accepts a modulus `m` and computes the Barrett constant `mu = floor(2^(2K) / m)` by restoring division, one quotient bit per cycle. It then presents `m` and `mu` together, stable, for the reduction pipeline's `m_i` / `mu_i` inputs.

---
 rtl/barrett_mu_precompute.sv | 133 +++++++++++++
 tb/tb_barrett_mu_precompute.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_mu_precompute.sv
// Computes the Barrett constant mu = floor(2^(2K) / m) by restoring division,
// one quotient bit per clock, and presents m and mu stable for the reduction stage.
module barrett_mu_precompute #(
    parameter int unsigned K = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [63:0] m_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [63:0] m_o,
    output logic [63:0] mu_o
);

    localparam int unsigned RW = K + 1;
    localparam int unsigned QW = 2 * K + 1;
    localparam int unsigned CW = $clog2(2 * K + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic            ready_q;
    logic            busy_q;
    logic            valid_q;
    logic            err_q;
    logic [63:0]     m_q;
    logic [63:0]     mu_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   rem_q;
    logic [RW-1:0]   dvs_q;
    logic [QW-1:0]   quo_q;

    logic            m_legal_c;
    logic            div_bit_c;
    logic [RW-1:0]   rem_shift_c;
    logic [RW-1:0]   rem_diff_c;
    logic            q_bit_c;
    logic [RW-1:0]   rem_nxt_c;
    logic [QW-1:0]   quo_nxt_c;
    logic            unused_c;

    assign m_legal_c = (m_i >= 64'd2) && ((m_i >> K) == 64'd0);

    // One restoring-division step; the remainder stays below m, so its top bit is never set
    always_comb begin
        div_bit_c   = (cnt_q == CW'(2 * K));
        rem_shift_c = {rem_q[K-1:0], div_bit_c};
        rem_diff_c  = rem_shift_c - dvs_q;
        q_bit_c     = (rem_shift_c >= dvs_q);
        rem_nxt_c   = q_bit_c ? rem_diff_c : rem_shift_c;
        quo_nxt_c   = {quo_q[QW-2:0], q_bit_c};
    end

    // Bits that are provably zero for any legal modulus
    assign unused_c = quo_q[QW-1] ^ rem_q[K];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            m_q     <= '0;
            mu_q    <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        m_q     <= m_i;
                        dvs_q   <= RW'(m_i[K-1:0]);
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= CW'(2 * K);
                        ready_q <= 1'b0;
                        if (m_legal_c) begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                        end else begin
                            // Illegal modulus reports immediately without dividing
                            state_q <= S_DONE;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            mu_q    <= '0;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nxt_c;
                    quo_q <= quo_nxt_c;
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        mu_q    <= 64'(quo_nxt_c[2*K-1:0]);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign m_o     = m_q;
    assign mu_o    = mu_q;

endmodule

// File: tb/tb_barrett_mu_precompute.sv
// Randomized scoreboard bench for barrett_mu_precompute: expected (m, mu, err, due cycle)
// is queued on every accept and popped by an output monitor on each valid pulse.
module tb_barrett_mu_precompute;

    localparam int unsigned K = 32;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [63:0] m_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic        err_o;
    logic [63:0] m_o;
    logic [63:0] mu_o;

    barrett_mu_precompute #(.K(K)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .m_i     (m_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .m_o     (m_o),
        .mu_o    (mu_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] m;
        logic [63:0] mu;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned n_accept = 0;
    int unsigned n_valid = 0;
    int unsigned n_flushed = 0;
    logic        valid_prev = 1'b0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division of 2^(2K) by m, with legality from the modulus rules
    function automatic exp_t model(input logic [63:0] m, input int unsigned acc);
        exp_t        e;
        logic [127:0] q;
        e.m = m;
        if (m < 64'd2 || (m >> K) != 64'd0) begin
            e.mu  = 64'd0;
            e.err = 1'b1;
            e.due = acc;
        end else begin
            q     = (128'd1 << (2 * K)) / {64'd0, m};
            e.mu  = q[63:0];
            e.err = 1'b0;
            e.due = acc + 2 * K + 1;
        end
        return e;
    endfunction

    // Accept monitor: the coming edge accepts when ready and start are both high
    always @(negedge clk_i) begin
        if (!rst_i && ready_o && start_i) begin
            sb.push_back(model(m_i, cyc + 1));
            n_accept++;
        end
    end

    // Output monitor
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            chk("state_onehot", 64'($countones({ready_o, busy_o, valid_o})), 64'd1);
            if (valid_o) begin
                n_valid++;
                chk("valid_single_cycle", 64'(valid_prev), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got valid with no request pending (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("m_o", m_o, e.m);
                    chk("mu_o", mu_o, e.mu);
                    chk("err_o", 64'(err_o), 64'(e.err));
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end
            valid_prev <= valid_o;
        end else begin
            valid_prev <= 1'b0;
        end
    end

    task automatic issue(input logic [63:0] m, input bit hold);
        int n = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (ready_o) break;
            if (++n > 400) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: ready_o stayed 0 for %0d cycles", n);
                return;
            end
        end
        m_i     = m;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (valid_o) start_i = 1'b0;
            if (sb.size() == 0 && ready_o && !start_i) break;
            if (++n > 600) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d results still pending", sb.size());
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        logic [63:0] m;
        logic [127:0] x, mm, q, r;
        int ncorr;
        bit hold;

        rst_i   = 1'b1;
        start_i = 1'b0;
        m_i     = '0;
        #12;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_err",   64'(err_o),   64'd0);
        chk("rst_m",     m_o,          64'd0);
        chk("rst_mu",    mu_o,         64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Directed legal values, including the maximum-mu boundary m=2
        issue(64'd3, 1'b0); drain();
        issue(64'd2, 1'b0); drain();

        // Back-to-back with start held high through DIV
        base = n_valid;
        issue(64'hFFFF_FFFF, 1'b1);
        issue(64'h8000_0000, 1'b1);
        issue(64'd10, 1'b1);
        drain();
        chk("b2b_valid_count", 64'(n_valid - base), 64'd3);

        // Illegal moduli overwrite the previous good result
        issue(64'd1, 1'b0);             drain();
        issue(64'd5, 1'b0);             drain();
        issue(64'd0, 1'b0);             drain();
        issue(64'h1_0000_0000, 1'b0);   drain();

        // Asynchronous reset in the middle of a division
        issue(64'd7, 1'b0);
        repeat (20) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("midrst_ready", 64'(ready_o), 64'd1);
        chk("midrst_busy",  64'(busy_o),  64'd0);
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_err",   64'(err_o),   64'd0);
        chk("midrst_m",     m_o,          64'd0);
        chk("midrst_mu",    mu_o,         64'd0);
        n_flushed += sb.size();
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        base = n_valid;
        repeat (80) @(posedge clk_i);
        #1;
        chk("midrst_no_valid", 64'(n_valid - base), 64'd0);
        issue(64'd7, 1'b0); drain();

        // Randomized mix of legal and illegal moduli
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0: m = 64'($urandom_range(0, 1));
                1: m = 64'd1 << (K + $urandom_range(0, 31));
                2: m = 64'($urandom_range(2, 20));
                default: begin
                    m = 64'($urandom);
                    if (m < 64'd2) m = 64'd2;
                end
            endcase
            hold = 1'($urandom_range(0, 1));
            issue(m, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk_i);
        end
        drain();

        // End-to-end Barrett reduction using the produced m_o / mu_o
        issue(64'hFFFF_FFFB, 1'b0); drain();
        chk("e2e_m_o", m_o, 64'hFFFF_FFFB);
        mm = {64'd0, m_o};
        for (int i = 0; i < 100; i++) begin
            x = {64'd0, $urandom, $urandom} % (mm * mm);
            q = ((x >> (K - 1)) * {64'd0, mu_o}) >> (K + 1);
            r = x - q * mm;
            ncorr = 0;
            while (r >= mm && ncorr < 4) begin
                r = r - mm;
                ncorr++;
            end
            chk("barrett_result", r[63:0], 64'(x % mm));
            if (ncorr > 2) chk("barrett_corrections", 64'(ncorr), 64'd2);
        end

        repeat (4) @(posedge clk_i);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("valid_total", 64'(n_valid), 64'(n_accept - n_flushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
